// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-stepped pong sequencer owning ball motion, serve timing, scoring and win detection.
// Everything advances only on cycles with frame_tick high; all outputs are registered.
module pong_game_ctrl #(
   parameter int SCR_W        = 640,
   parameter int SCR_H        = 480,
   parameter int BALL_SIZE    = 8,
   parameter int BALL_ISPX    = 5,
   parameter int BALL_ISPY    = 3,
   parameter int PAD_HEIGHT   = 48,
   parameter int PAD_WIDTH    = 10,
   parameter int PAD_OFFS     = 32,
   parameter int SPEEDUP      = 5,
   parameter int SPX_MAX      = 12,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_start,
   input  logic [9:0] padl_y,
   input  logic [9:0] padr_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [2:0] state,
   output logic       hit
);
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
   localparam int CW = $clog2(SERVE_FRAMES + 1);
   localparam logic [9:0] XC = 10'((SCR_W - BALL_SIZE) / 2);
   localparam logic [9:0] YC = 10'((SCR_H - BALL_SIZE) / 2);
   localparam logic [9:0] XMAX = 10'(SCR_W - BALL_SIZE);
   localparam logic [9:0] YMAX = 10'(SCR_H - BALL_SIZE);
   localparam logic [9:0] XL = 10'(PAD_OFFS + PAD_WIDTH);
   localparam logic [9:0] XR = 10'(SCR_W - PAD_OFFS - PAD_WIDTH - 1 - BALL_SIZE);
   localparam logic [9:0] STEPY = 10'(BALL_ISPY);
   localparam logic [10:0] LF = 11'(PAD_OFFS + PAD_WIDTH);
   localparam logic [10:0] RF = 11'(SCR_W - PAD_OFFS - PAD_WIDTH - 1);
   localparam logic [10:0] BS = 11'(BALL_SIZE);
   localparam logic [10:0] SPY = 11'(BALL_ISPY);
   localparam logic [10:0] PH = 11'(PAD_HEIGHT);
   localparam logic [10:0] W = 11'(SCR_W);
   localparam logic [10:0] H = 11'(SCR_H);
   localparam logic [3:0] ISPX = 4'(BALL_ISPX);
   localparam logic [3:0] SPMAX = 4'(SPX_MAX);
   localparam logic [3:0] NHIT = 4'(SPEEDUP);
   localparam logic [3:0] WIN = 4'(WIN_SCORE);
   localparam logic [CW-1:0] SLAST = CW'(SERVE_FRAMES - 1);

   state_t        state_q, state_d;
   logic [9:0]    ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
   logic [3:0]    spx_q, spx_d, shot_q, shot_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dx_q, dx_d, dy_q, dy_d, hit_q, hit_d, scorer_q, scorer_d;
   logic [10:0]   bx, by, sp, pl, pr;
   logic          olap_l, olap_r, hit_l, hit_r, miss_l, miss_r, speed_up;
   logic [3:0]    new_score;

   // 11-bit views so sums near the right/bottom edge cannot wrap
   assign bx = {1'b0, ball_x_q};
   assign by = {1'b0, ball_y_q};
   assign sp = {7'b0, spx_q};
   assign pl = {1'b0, padl_y};
   assign pr = {1'b0, padr_y};
   assign olap_l = (by + BS > pl) && (by < pl + PH);
   assign olap_r = (by + BS > pr) && (by < pr + PH);
   assign hit_l = !dx_q && bx >= LF && bx - sp < LF && olap_l;
   assign hit_r = dx_q && bx + BS <= RF && bx + BS + sp > RF && olap_r;
   assign miss_l = !dx_q && bx < sp;
   assign miss_r = dx_q && bx + BS + sp >= W;
   assign speed_up = shot_q + 4'd1 == NHIT;
   assign new_score = scorer_q ? score_l_q + 4'd1 : score_r_q + 4'd1;

   always_comb begin
      state_d = state_q;
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      spx_d = spx_q;
      shot_d = shot_q;
      cnt_d = cnt_q;
      dx_d = dx_q;
      dy_d = dy_q;
      scorer_d = scorer_q;
      hit_d = 1'b0;
      if (frame_tick) begin
         case (state_q)
            IDLE: begin
               ball_x_d = XC;
               ball_y_d = YC;
               score_l_d = '0;
               score_r_d = '0;
               if (btn_start) state_d = SERVE;
            end
            SERVE: begin
               ball_x_d = XC;
               ball_y_d = YC;
               spx_d = ISPX;
               shot_d = '0;
               cnt_d = (cnt_q == SLAST) ? '0 : cnt_q + 1'b1;
               if (cnt_q == SLAST) state_d = PLAY;
            end
            PLAY: begin
               if (dy_q && by + BS + SPY >= H) begin
                  ball_y_d = YMAX;
                  dy_d = 1'b0;
               end else if (!dy_q && by < SPY) begin
                  ball_y_d = '0;
                  dy_d = 1'b1;
               end else ball_y_d = dy_q ? ball_y_q + STEPY : ball_y_q - STEPY;
               // a paddle contact takes priority over a miss on the same frame
               if (hit_l || hit_r) begin
                  ball_x_d = hit_l ? XL : XR;
                  dx_d = hit_l;
                  hit_d = 1'b1;
                  shot_d = speed_up ? '0 : shot_q + 4'd1;
                  spx_d = (speed_up && spx_q < SPMAX) ? spx_q + 4'd1 : spx_q;
               end else if (miss_l || miss_r) begin
                  ball_x_d = miss_l ? '0 : XMAX;
                  scorer_d = miss_r;
                  state_d = POINT;
               end else ball_x_d = dx_q ? ball_x_q + 10'(spx_q) : ball_x_q - 10'(spx_q);
            end
            POINT: begin
               ball_x_d = XC;
               ball_y_d = YC;
               score_l_d = scorer_q ? new_score : score_l_q;
               score_r_d = scorer_q ? score_r_q : new_score;
               dx_d = scorer_q;
               if (new_score == WIN) state_d = OVER;
               else begin
                  state_d = SERVE;
                  dy_d = ~dy_q;
               end
            end
            OVER: begin
               ball_x_d = XC;
               ball_y_d = YC;
               if (btn_start) begin
                  state_d = SERVE;
                  score_l_d = '0;
                  score_r_d = '0;
                  dx_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ball_x_q <= XC;
         ball_y_q <= YC;
         score_l_q <= '0;
         score_r_q <= '0;
         spx_q <= ISPX;
         shot_q <= '0;
         cnt_q <= '0;
         dx_q <= 1'b1;
         dy_q <= 1'b1;
         scorer_q <= 1'b0;
         hit_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         spx_q <= spx_d;
         shot_q <= shot_d;
         cnt_q <= cnt_d;
         dx_q <= dx_d;
         dy_q <= dy_d;
         scorer_q <= scorer_d;
         hit_q <= hit_d;
      end
   end

   assign ball_x = ball_x_q;
   assign ball_y = ball_y_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign state = state_q;
   assign hit = hit_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: randomized frame stimulus; an integer model of the game rules predicts each frame's
// outputs into a scoreboard that a separate monitor drains whenever a frame tick has been consumed.
module tb_pong_game_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, btn_start = 1'b0;
   logic [9:0] padl_y = '0, padr_y = '0;
   logic [9:0] ball_x, ball_y;
   logic [3:0] score_l, score_r;
   logic [2:0] state;
   logic       hit;

   typedef struct {int st; int x; int y; int sl; int sr; int h;} exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0;
   int m_st, m_x, m_y, m_dx, m_dy, m_spx, m_shot, m_sl, m_sr, m_cnt, m_hit;
   int max_spx = 5, n_hits = 0;
   bit m_lscored;

   pong_game_ctrl dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_start(btn_start),
      .padl_y(padl_y), .padr_y(padr_y), .ball_x(ball_x), .ball_y(ball_y),
      .score_l(score_l), .score_r(score_r), .state(state), .hit(hit)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, int'(state), 0);
      check({tag, "_x"}, int'(ball_x), 316);
      check({tag, "_y"}, int'(ball_y), 236);
      check({tag, "_score_l"}, int'(score_l), 0);
      check({tag, "_score_r"}, int'(score_r), 0);
      check({tag, "_hit"}, int'(hit), 0);
   endtask

   task automatic model_reset();
      m_st = 0; m_x = 316; m_y = 236; m_dx = 1; m_dy = 1; m_spx = 5; m_shot = 0;
      m_sl = 0; m_sr = 0; m_cnt = 0; m_hit = 0;
   endtask

   task automatic serve_start();
      m_st = 1; m_x = 316; m_y = 236; m_spx = 5; m_shot = 0; m_cnt = 0;
   endtask

   function automatic bit covers(input int bally, input int pad);
      return (bally + 8 > pad) && (bally < pad + 48);
   endfunction

   // game rules in plain integers: dx/dy are +1/-1 directions, positions are signed ints
   task automatic model_tick(input bit btn, input int pl, input int pr);
      int oy;
      m_hit = 0;
      oy = m_y;
      case (m_st)
         0: if (btn) serve_start();
         1: begin
            m_cnt++;
            if (m_cnt == 60) begin m_st = 2; m_cnt = 0; end
         end
         2: begin
            if (m_dy > 0) begin
               if (m_y + 11 >= 480) begin m_y = 472; m_dy = -1; end else m_y += 3;
            end else if (m_y < 3) begin m_y = 0; m_dy = 1; end else m_y -= 3;
            if (m_dx < 0 && m_x >= 42 && m_x - m_spx < 42 && covers(oy, pl)) begin
               m_x = 42; m_dx = 1; m_hit = 1;
            end else if (m_dx > 0 && m_x + 8 <= 597 && m_x + 8 + m_spx > 597 && covers(oy, pr)) begin
               m_x = 589; m_dx = -1; m_hit = 1;
            end else if (m_dx < 0 && m_x - m_spx < 0) begin
               m_x = 0; m_lscored = 0; m_st = 3;
            end else if (m_dx > 0 && m_x + 8 + m_spx >= 640) begin
               m_x = 632; m_lscored = 1; m_st = 3;
            end else m_x += m_dx * m_spx;
            if (m_hit != 0) begin
               n_hits++;
               m_shot++;
               if (m_shot == 5) begin m_shot = 0; m_spx = (m_spx + 1 > 12) ? 12 : m_spx + 1; end
            end
            if (m_spx > max_spx) max_spx = m_spx;
         end
         3: begin
            if (m_lscored) begin m_sl++; m_dx = 1; end else begin m_sr++; m_dx = -1; end
            m_x = 316; m_y = 236;
            if (m_sl == 9 || m_sr == 9) m_st = 4;
            else begin m_dy = -m_dy; serve_start(); end
         end
         4: if (btn) begin m_sl = 0; m_sr = 0; m_dx = 1; serve_start(); end
         default: ;
      endcase
   endtask

   // mode 0: random row, 1: cover the ball, 2: stay clear of the ball
   function automatic int pad_for(input int mode, input int bally);
      int p;
      if (mode == 0) return int'($urandom_range(0, 1023));
      if (mode == 2) return (bally >= 240) ? 0 : 432;
      p = bally - int'($urandom_range(0, 39));
      return (p < 0) ? 0 : ((p > 432) ? 432 : p);
   endfunction

   task automatic frame(input bit btn, input int lmode, input int rmode, input bit multi);
      int hold, pl, pr;
      hold = (multi && $urandom_range(0, 9) == 0) ? 2 : 1;
      pl = pad_for(lmode, m_y);
      pr = pad_for(rmode, m_y);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         btn_start = btn; padl_y = 10'(pl); padr_y = 10'(pr); frame_tick = 1'b1;
         model_tick(btn, pl, pr);
         sb.push_back('{m_st, m_x, m_y, m_sl, m_sr, m_hit});
      end
      @(negedge clk);
      frame_tick = 1'b0; btn_start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   always @(posedge clk) begin
      if (rst_n && frame_tick) begin
         @(negedge clk);
         if (sb.size() == 0) check("sb_underflow", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("state", int'(state), e.st);
            check("ball_x", int'(ball_x), e.x);
            check("ball_y", int'(ball_y), e.y);
            check("score_l", int'(score_l), e.sl);
            check("score_r", int'(score_r), e.sr);
            check("hit", int'(hit), e.h);
         end
      end else if (rst_n) begin
         @(negedge clk);
         check("hit_idle", int'(hit), 0);
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      repeat (10) frame(1'b0, 0, 0, 1'b0);
      check("idle_hold", int'(state), 0);
      frame(1'b1, 0, 0, 1'b0);
      check("serve_entry", int'(state), 1);
      repeat (60) frame(1'b0, 0, 0, 1'b0);
      check("play_entry", int'(state), 2);
      frame(1'b0, 0, 0, 1'b0);
      check("first_x", int'(ball_x), 321);
      check("first_y", int'(ball_y), 239);
      for (int i = 0; i < 3500 && n_hits < 40; i++) frame(1'(($urandom_range(0, 1))), 1, 1, 1'b1);
      $display("rally: %0d paddle hits, top speed %0d", n_hits, max_spx);
      for (int i = 0; i < 1000 && m_sl == 0; i++) frame(1'b0, 1, 2, 1'b1);
      check("left_point_score", int'(score_l), 1);
      check("left_point_serve", int'(state), 1);
      check("left_point_x", int'(ball_x), 316);
      for (int i = 0; i < 4000 && m_st != 4; i++) frame(1'b0, 2, 1, 1'b1);
      check("over_state", int'(state), 4);
      check("over_score_r", int'(score_r), 9);
      repeat (3) frame(1'b0, 0, 0, 1'b1);
      frame(1'b1, 0, 0, 1'b0);
      check("restart_state", int'(state), 1);
      check("restart_score_l", int'(score_l), 0);
      check("restart_score_r", int'(score_r), 0);
      repeat (70) frame(1'b0, 1, 1, 1'b0);
      check("pre_reset_play", int'(state), 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("midplay_reset");
      check("sb_empty_at_reset", sb.size(), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) frame(1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
